// File: rtl/reg_file_pkg.sv
// Shared RV32 integer register-file types and constants.
// Pure declarations: no logic, no timing.
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read mux over the register array; index 0 always returns zero.
// Zero-cycle latency, no backpressure (pure combinational lookup).
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               idx,
    output logic [DATA_W-1:0]               data
);

    always_comb begin
        data = '0;
        if (idx != ADDR_W'(ZERO_REG)) begin
            data = regs[idx];
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32 integer register file: 2 combinational read ports, 1 stall-gated write port, x0 hardwired to 0.
// Reads have zero latency; writes land on the rising edge; stall simply drops the write (no queuing).
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              we,
    input  logic              stall,
    output logic [DATA_W-1:0] rs1d,
    output logic [DATA_W-1:0] rs2d
);

    // Only x1..x31 hold state; x0 is supplied as a constant in the read view.
    logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_all;
    logic                            wr_en;

    assign wr_en    = we && !stall && (rd != ADDR_W'(ZERO_REG));
    assign regs_all = {regs_q, {DATA_W{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && (rd == ADDR_W'(i))) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // No write-to-read bypass: the pipeline forwards wb_data itself when needed.
    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_port_rs1 (
        .regs (regs_all),
        .idx  (rs1),
        .data (rs1d)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_port_rs2 (
        .regs (regs_all),
        .idx  (rs2),
        .data (rs2d)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, x0, stall gating, dual-port timing, async reset.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        we;
    logic        stall;
    logic [31:0] rs1d;
    logic [31:0] rs2d;

    int total = 0;
    int bad   = 0;

    reg_file dut (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .wb_data (wb_data),
        .we      (we),
        .stall   (stall),
        .rs1d    (rs1d),
        .rs2d    (rs2d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_set(input logic [4:0] a, input logic [4:0] b);
        rs1 = a;
        rs2 = b;
        #1;
    endtask

    // Present a write at the falling edge, let the rising edge take it, then deassert.
    task automatic wr(input logic [4:0] addr, input logic [31:0] data,
                      input logic wen, input logic stl);
        @(negedge clk);
        rd      = addr;
        wb_data = data;
        we      = wen;
        stall   = stl;
        @(posedge clk);
        #1;
        we    = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        wb_data = '0;
        we      = 1'b0;
        stall   = 1'b0;

        // Reset clear
        repeat (3) @(posedge clk);
        #1;
        rd_set(5'd5, 5'd31);
        chk("rst_hold_rs1", rs1d, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd_set(5'd5, 5'd31);
        chk("rst_rel_rs1_x5", rs1d, 32'h0000_0000);
        chk("rst_rel_rs2_x31", rs2d, 32'h0000_0000);

        // Basic write/read, with a pre-edge look at the target
        @(negedge clk);
        rd = 5'd3; wb_data = 32'hDEAD_BEEF; we = 1'b1; stall = 1'b0;
        rd_set(5'd3, 5'd4);
        chk("wr_x3_pre_edge", rs1d, 32'h0000_0000);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_set(5'd3, 5'd4);
        chk("wr_x3_post_edge", rs1d, 32'hDEAD_BEEF);
        chk("x4_untouched", rs2d, 32'h0000_0000);

        // x0 immutability
        wr(5'd0, 32'h1234_5678, 1'b1, 1'b0);
        rd_set(5'd0, 5'd0);
        chk("x0_rs1", rs1d, 32'h0000_0000);
        chk("x0_rs2", rs2d, 32'h0000_0000);

        // Stall gating
        wr(5'd7, 32'h0000_0011, 1'b1, 1'b0);
        rd_set(5'd7, 5'd0);
        chk("x7_preload", rs1d, 32'h0000_0011);
        wr(5'd7, 32'hFFFF_FFFF, 1'b1, 1'b1);
        rd_set(5'd7, 5'd0);
        chk("x7_stalled", rs1d, 32'h0000_0011);
        wr(5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rd_set(5'd7, 5'd0);
        chk("x7_unstalled", rs1d, 32'hFFFF_FFFF);
        wr(5'd7, 32'h0000_0022, 1'b0, 1'b0);
        rd_set(5'd7, 5'd0);
        chk("x7_we0", rs1d, 32'hFFFF_FFFF);

        // Dual port and write timing
        wr(5'd10, 32'hA5A5_A5A5, 1'b1, 1'b0);
        wr(5'd11, 32'h5A5A_5A5A, 1'b1, 1'b0);
        rd_set(5'd10, 5'd11);
        chk("dual_rs1_x10", rs1d, 32'hA5A5_A5A5);
        chk("dual_rs2_x11", rs2d, 32'h5A5A_5A5A);
        rd_set(5'd10, 5'd10);
        chk("same_rs1_x10", rs1d, 32'hA5A5_A5A5);
        chk("same_rs2_x10", rs2d, 32'hA5A5_A5A5);
        @(negedge clk);
        rd = 5'd10; wb_data = 32'h0000_0001; we = 1'b1;
        rd_set(5'd10, 5'd10);
        chk("x10_pre_edge", rs1d, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("x10_post_edge_rs1", rs1d, 32'h0000_0001);
        chk("x10_post_edge_rs2", rs2d, 32'h0000_0001);

        // Fill x1..x31 with their index, spot-check
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i), 1'b1, 1'b0);
        end
        rd_set(5'd1, 5'd31);
        chk("fill_x1", rs1d, 32'd1);
        chk("fill_x31", rs2d, 32'd31);
        rd_set(5'd9, 5'd17);
        chk("fill_x9", rs1d, 32'd9);
        chk("fill_x17", rs2d, 32'd17);

        // Async reset between edges, with a write presented during reset
        @(negedge clk);
        #2;
        reset = 1'b0;
        rd = 5'd9; wb_data = 32'hCAFE_F00D; we = 1'b1; stall = 1'b0;
        rd_set(5'd9, 5'd31);
        chk("async_x9_before_edge", rs1d, 32'h0000_0000);
        chk("async_x31_before_edge", rs2d, 32'h0000_0000);
        for (int i = 1; i < 32; i++) begin
            rd_set(5'(i), 5'(32 - i));
            chk($sformatf("async_rs1_x%0d", i), rs1d, 32'h0000_0000);
            chk($sformatf("async_rs2_x%0d", 32 - i), rs2d, 32'h0000_0000);
        end
        @(posedge clk);
        #1;
        rd_set(5'd9, 5'd9);
        chk("rst_write_dropped", rs1d, 32'h0000_0000);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        rd_set(5'd9, 5'd10);
        chk("post_rel_x9", rs1d, 32'h0000_0000);
        chk("post_rel_x10", rs2d, 32'h0000_0000);

        // First write lands on the first rising edge after release
        @(negedge clk);
        rd = 5'd9; wb_data = 32'hCAFE_F00D; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_set(5'd9, 5'd0);
        chk("first_write_x9", rs1d, 32'hCAFE_F00D);
        chk("first_write_x0", rs2d, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
